// File: rtl/vga_bar_graph.sv
// vga_bar_graph: VGA raster generator that draws N_BARS vertical level bars
// with decaying peak markers. Bar levels arrive over a slow SPI slave link
// and are double-buffered so a frame never shows a half-updated set of bars.
module vga_bar_graph #(
    parameter int N_BARS  = 15,
    parameter int BAR_W   = 53,
    parameter int LVL_W   = 8,
    parameter int V_SCALE = 2,
    parameter int DECAY   = 1,
    parameter int H_TOTAL = 1050,
    parameter int H_SYNC  = 141,
    parameter int H_ACT_S = 231,
    parameter int H_ACT_E = 1019,
    parameter int V_TOTAL = 798,
    parameter int V_SYNC  = 6,
    parameter int V_ACT_S = 35,
    parameter int V_ACT_E = 795
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic       spi_clk,
    input  logic       spi_csel,
    input  logic       spi_mosi,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start,
    output logic       spi_err
);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int BIW = (N_BARS > 1) ? $clog2(N_BARS) : 1;
    // Wide enough for level*V_SCALE without truncation and for row[8:1].
    localparam int CW  = LVL_W + VW + 9;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_S_C = HW'(H_ACT_S);
    localparam logic [HW-1:0] H_ACT_E_C = HW'(H_ACT_E);
    localparam logic [HW-1:0] BAR_C     = HW'(BAR_W);
    localparam logic [HW-1:0] SEP_C     = HW'(BAR_W - 3);
    localparam logic [HW-1:0] NB_C      = HW'(N_BARS);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_S_C = VW'(V_ACT_S);
    localparam logic [VW-1:0] V_ACT_E_C = VW'(V_ACT_E);
    localparam logic [VW-1:0] ROW_TOP   = VW'(V_ACT_E - 1);
    localparam logic [CW-1:0] VS_CW     = CW'(V_SCALE);
    localparam logic [8:0]    NB_ADDR   = 9'(N_BARS);
    localparam logic [LVL_W-1:0] DEC_C  = LVL_W'(DECAY);

    // Peak decrement that stops at zero instead of wrapping.
    function automatic logic [LVL_W-1:0] sat0_dec(input logic [LVL_W-1:0] pk);
        return (pk > DEC_C) ? (pk - DEC_C) : '0;
    endfunction

    // New peak: the larger of the fresh level and the decayed old peak.
    function automatic logic [LVL_W-1:0] peak_next(input logic [LVL_W-1:0] lvl,
                                                   input logic [LVL_W-1:0] pk);
        logic [LVL_W-1:0] dec;
        dec = sat0_dec(pk);
        return (lvl > dec) ? lvl : dec;
    endfunction

    logic rst_n;
    logic unused_keys;
    assign rst_n       = KEY[0];
    assign unused_keys = ^KEY[3:1];

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    logic [2:0] sclk_q, csel_q;
    logic [1:0] mosi_q;
    logic       sclk_rise, csel_rise, csel_fall;

    logic [15:0]      pkt_q, pkt_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             spi_err_q, spi_err_d;
    logic             wr_en;
    logic [BIW-1:0]   wr_idx;
    logic [LVL_W-1:0] wr_val;

    logic [LVL_W-1:0] shadow_q [N_BARS];
    logic [LVL_W-1:0] act_q    [N_BARS];
    logic [LVL_W-1:0] peak_q   [N_BARS];

    logic          active, sep, pk_hit, body_hit;
    logic [HW-1:0] x, bar, col;
    logic [BIW-1:0] bidx;
    logic [VW-1:0] row;
    logic [CW-1:0] row_w, body_lim, pk_row;
    logic [7:0]    shade;
    logic [7:0]    r_q, g_q, b_q, r_d, g_d, b_d;
    logic          hs_q, vs_q, blank_q, hs_d, vs_d, blank_d;

    assign VGA_CLK     = CLOCK_50;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign spi_err     = spi_err_q;
    assign frame_start = rst_n && (h_q == '0) && (v_q == '0);

    // Raster position: h wraps each line, v advances on h wrap.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Raster counter registers.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Pixel colour and sync levels for the current raster position.
    always_comb begin
        active   = (h_q >= H_ACT_S_C) && (h_q < H_ACT_E_C) &&
                   (v_q >= V_ACT_S_C) && (v_q < V_ACT_E_C);
        x        = h_q - H_ACT_S_C;
        bar      = x / BAR_C;
        col      = x % BAR_C;
        sep      = (col >= SEP_C) || (bar >= NB_C);
        bidx     = (bar < NB_C) ? bar[BIW-1:0] : '0;
        row      = ROW_TOP - v_q;
        row_w    = CW'(row);
        body_lim = CW'(act_q[bidx]) * VS_CW;
        pk_row   = row_w / VS_CW;
        pk_hit   = (pk_row == CW'(peak_q[bidx]));
        body_hit = (row_w < body_lim);
        shade    = row_w[8:1];
        hs_d     = (h_q >= H_SYNC_C);
        vs_d     = (v_q >= V_SYNC_C);
        blank_d  = active;
        r_d      = 8'h00;
        g_d      = 8'h00;
        b_d      = 8'h00;
        if (active && !sep) begin
            if (pk_hit) begin
                r_d = 8'hFF;
                g_d = 8'hFF;
                b_d = 8'hFF;
            end else if (body_hit) begin
                r_d = shade;
                g_d = 8'hFF - shade;
            end else begin
                r_d = 8'h60;
                g_d = 8'h60;
                b_d = 8'h60;
            end
        end
    end

    // Registered VGA outputs, one clock behind the counters.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
        end
    end

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            sclk_q <= '0;
            csel_q <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            csel_q <= {csel_q[1:0], spi_csel};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign csel_rise = csel_q[1] & ~csel_q[2];
    assign csel_fall = ~csel_q[1] & csel_q[2];

    // SPI receiver: LSB-first shift, saturating bit count, commit on csel fall.
    always_comb begin
        pkt_d     = pkt_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        spi_err_d = 1'b0;
        wr_idx    = pkt_q[BIW-1:0];
        wr_val    = LVL_W'(pkt_q[15:8]);
        if (csel_rise) begin
            cnt_d = '0;
        end else if (csel_q[1] && sclk_rise) begin
            pkt_d = {mosi_q[1], pkt_q[15:1]};
            if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
        if (csel_fall) begin
            if ((cnt_q == 5'd16) && ({1'b0, pkt_q[7:0]} < NB_ADDR)) wr_en = 1'b1;
            else spi_err_d = 1'b1;
        end
    end

    // SPI receiver state registers.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            pkt_q     <= '0;
            cnt_q     <= '0;
            spi_err_q <= 1'b0;
        end else begin
            pkt_q     <= pkt_d;
            cnt_q     <= cnt_d;
            spi_err_q <= spi_err_d;
        end
    end

    // Shadow takes SPI writes any time; act and peak update only at frame start.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BARS; i++) begin
                shadow_q[i] <= '0;
                act_q[i]    <= '0;
                peak_q[i]   <= '0;
            end
        end else begin
            if (wr_en) shadow_q[wr_idx] <= wr_val;
            if (frame_start) begin
                for (int i = 0; i < N_BARS; i++) begin
                    act_q[i]  <= shadow_q[i];
                    peak_q[i] <= peak_next(shadow_q[i], peak_q[i]);
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_bar_graph.sv
// Directed bench for vga_bar_graph, run on a shrunken raster so many frames fit.
module tb_vga_bar_graph;
    localparam int NB = 4, BW = 6, LW = 8, VSC = 2, DEC = 1;
    localparam int HT = 40, HSY = 4, HAS = 8, HAE = 38;
    localparam int VT = 24, VSY = 2, VAS = 4, VAE = 23;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic       sclk, csel, mosi;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, fs, serr;

    always #5 clk = ~clk;

    vga_bar_graph #(
        .N_BARS(NB), .BAR_W(BW), .LVL_W(LW), .V_SCALE(VSC), .DECAY(DEC),
        .H_TOTAL(HT), .H_SYNC(HSY), .H_ACT_S(HAS), .H_ACT_E(HAE),
        .V_TOTAL(VT), .V_SYNC(VSY), .V_ACT_S(VAS), .V_ACT_E(VAE)
    ) dut (
        .CLOCK_50(clk), .KEY(key),
        .spi_clk(sclk), .spi_csel(csel), .spi_mosi(mosi),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_CLK(vga_clk), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n),
        .frame_start(fs), .spi_err(serr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int th = 0, tv = 0, ph = -1, pv = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected raster position; (ph,pv) is the position the outputs show now.
    always @(posedge clk) begin
        if (!key[0]) begin
            th <= 0; tv <= 0; ph <= -1; pv <= -1;
        end else begin
            ph <= th;
            pv <= tv;
            if (th == HT - 1) begin
                th <= 0;
                tv <= (tv == VT - 1) ? 0 : tv + 1;
            end else begin
                th <= th + 1;
            end
        end
    end

    always @(negedge clk) if (serr === 1'b1) err_cnt <= err_cnt + 1;

    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (!(ph == h && pv == v) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_%0d_%0d", h, v), 32'(ph == h && pv == v), 32'd1);
    endtask

    task automatic px(input string tag, input int h, input int v,
                      input logic [23:0] rgb, input logic blank);
        goto(h, v);
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(rgb));
        chk({tag, "_blank"}, 32'(vga_blank_n), 32'(blank));
    endtask

    task automatic bar_px(input string tag, input int b, input int c, input int r,
                          input logic [23:0] rgb);
        px(tag, HAS + b * BW + c, VAE - 1 - r, rgb, 1'b1);
    endtask

    // Stops on the negedge where frame_start is high (load edge not yet taken).
    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge clk);
        while (fs !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("fs_seen", 32'(fs), 32'd1);
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] p, input int n);
        csel = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) spi_bit(p[i]);
        repeat (4) @(negedge clk);
        csel = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int hs_lo, vs_lo, fs_n;
        int fs_at [2];
        logic [7:0] exp_sh [NB];
        logic [15:0] partial;

        key = 4'b1110; sclk = 1'b0; csel = 1'b0; mosi = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_hs", 32'(vga_hs), 32'd0);
        chk("rst_vs", 32'(vga_vs), 32'd0);
        chk("rst_blank", 32'(vga_blank_n), 32'd0);
        chk("rst_fs", 32'(fs), 32'd0);
        chk("rst_err", 32'(serr), 32'd0);
        chk("sync_n", 32'(vga_sync_n), 32'd1);
        chk("vga_clk", 32'(vga_clk), 32'(clk));

        key[0] = 1'b1;
        #1;
        chk("fs_first", 32'(fs), 32'd1);

        // Two full frames of sync/frame_start timing.
        hs_lo = 0; vs_lo = 0; fs_n = 0; fs_at[0] = 0; fs_at[1] = 0;
        @(negedge clk);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            if (fs) begin
                if (fs_n < 2) fs_at[fs_n] = i;
                fs_n++;
            end
            @(negedge clk);
        end
        chk("hs_low_clks", 32'(hs_lo), 32'(2 * VT * HSY));
        chk("vs_low_clks", 32'(vs_lo), 32'(2 * VSY * HT));
        chk("fs_count", 32'(fs_n), 32'd2);
        chk("fs_period", 32'(fs_at[1] - fs_at[0]), 32'(FRAME));

        // Blanking and idle-bar pixels, in raster order.
        px("vblank_top", 20, 1, 24'h0, 1'b0);
        px("hblank_left", 2, 10, 24'h0, 1'b0);
        px("hblank_right", 38, 10, 24'h0, 1'b0);
        bar_px("idle_bg", 0, 1, 10, 24'h606060);
        bar_px("idle_peak0", 0, 0, 0, 24'hFFFFFF);
        px("vblank_bot", 20, 23, 24'h0, 1'b0);

        // Mid-frame writes must wait for the next frame_start.
        wait_fs();
        @(negedge clk);
        spi_xfer({8'd100, 8'd3}, 16);
        spi_xfer({8'd4, 8'd1}, 16);
        spi_xfer({8'd130, 8'd2}, 16);
        chk("shadow3_wr", 32'(dut.shadow_q[3]), 32'd100);
        chk("act3_midframe", 32'(dut.act_q[3]), 32'd0);
        wait_fs();
        chk("act3_at_fs", 32'(dut.act_q[3]), 32'd0);
        @(negedge clk);
        chk("act3_loaded", 32'(dut.act_q[3]), 32'd100);
        chk("peak3_loaded", 32'(dut.peak_q[3]), 32'd100);
        chk("act1_loaded", 32'(dut.act_q[1]), 32'd4);
        chk("act2_loaded", 32'(dut.act_q[2]), 32'd130);

        bar_px("b3_row18", 3, 0, 18, 24'h09F600);
        bar_px("b1_row10_bg", 1, 1, 10, 24'h606060);
        bar_px("b2_row10_wide", 2, 0, 10, 24'h05FA00);
        bar_px("b1_row9_peak", 1, 0, 9, 24'hFFFFFF);
        bar_px("b1_row8_peak", 1, 0, 8, 24'hFFFFFF);
        bar_px("b1_row7_body", 1, 0, 7, 24'h03FC00);
        for (int b = 0; b < NB; b++)
            for (int c = BW - 3; c < BW; c++)
                bar_px($sformatf("sep_b%0d_c%0d", b, c), b, c, 5, 24'h0);
        bar_px("past_bars_x24", 0, NB * BW, 5, 24'h0);
        bar_px("past_bars_x29", 0, 29, 5, 24'h0);
        bar_px("b3_row0", 3, 2, 0, 24'h00FF00);

        // Bad frames: short packet and out-of-range address.
        chk("err_none", 32'(err_cnt), 32'd0);
        spi_xfer({8'd5, 8'd0}, 15);
        chk("err_short", 32'(err_cnt), 32'd1);
        spi_xfer({8'd9, 8'd20}, 16);
        chk("err_addr", 32'(err_cnt), 32'd2);
        exp_sh[0] = 8'd0; exp_sh[1] = 8'd4; exp_sh[2] = 8'd130; exp_sh[3] = 8'd100;
        for (int i = 0; i < NB; i++)
            chk($sformatf("shadow%0d_kept", i), 32'(dut.shadow_q[i]), 32'(exp_sh[i]));

        // Peak decay on bar 0.
        spi_xfer({8'd50, 8'd0}, 16);
        wait_fs(); @(negedge clk);
        chk("peak0_50", 32'(dut.peak_q[0]), 32'd50);
        spi_xfer({8'd0, 8'd0}, 16);
        wait_fs(); @(negedge clk);
        chk("peak0_49", 32'(dut.peak_q[0]), 32'd49);
        wait_fs(); @(negedge clk);
        chk("peak0_48", 32'(dut.peak_q[0]), 32'd48);
        repeat (47) begin wait_fs(); @(negedge clk); end
        chk("peak0_1", 32'(dut.peak_q[0]), 32'd1);
        wait_fs(); @(negedge clk);
        chk("peak0_0", 32'(dut.peak_q[0]), 32'd0);
        wait_fs(); @(negedge clk);
        chk("peak0_floor", 32'(dut.peak_q[0]), 32'd0);
        chk("act0_zero", 32'(dut.act_q[0]), 32'd0);

        // Reset in the middle of a packet, then a clean write.
        partial = {8'd9, 8'd2};
        csel = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) spi_bit(partial[i]);
        key[0] = 1'b0; csel = 1'b0; sclk = 1'b0; mosi = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_shadow3", 32'(dut.shadow_q[3]), 32'd0);
        key[0] = 1'b1;
        repeat (3) @(negedge clk);
        spi_xfer({8'd7, 8'd1}, 16);
        chk("post_rst_s0", 32'(dut.shadow_q[0]), 32'd0);
        chk("post_rst_s1", 32'(dut.shadow_q[1]), 32'd7);
        chk("post_rst_s2", 32'(dut.shadow_q[2]), 32'd0);
        chk("post_rst_s3", 32'(dut.shadow_q[3]), 32'd0);
        chk("post_rst_err", 32'(err_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_bar_graph.md
VGA_BAR_GRAPH -- requirements
Module: vga_bar_graph

Interface
REQ-001 The module SHALL have parameter N_BARS, default 15, meaning the number of displayed bars (1..32).
REQ-002 The module SHALL have parameter BAR_W, default 53, meaning the bar pitch in pixel clocks, including a 3-pixel separator.
REQ-003 The module SHALL have parameter LVL_W, default 8, meaning the bar level width in bits.
REQ-004 The module SHALL have parameter V_SCALE, default 2, meaning the number of rows per level step.
REQ-005 The module SHALL have parameter DECAY, default 1, meaning the peak-marker decrement per frame.
REQ-006 The module SHALL have timing parameters with these defaults: H_TOTAL 1050, H_SYNC 141, H_ACT_S 231, H_ACT_E 1019, V_TOTAL 798, V_SYNC 6, V_ACT_S 35, V_ACT_E 795.
REQ-007 Port CLOCK_50: input, 1 bit; the single clock, also the pixel clock.
REQ-008 Port KEY: input, 4 bits; KEY[0] is the synchronous active-low reset; KEY[3:1] are unused.
REQ-009 Port spi_clk, spi_csel, spi_mosi: inputs, 1 bit each; asynchronous SPI slave inputs; csel is active high.
REQ-010 Port VGA_R, VGA_G, VGA_B: outputs, 8 bits each; pixel colour.
REQ-011 Port VGA_CLK: output, 1 bit; equal to CLOCK_50.
REQ-012 Port VGA_HS, VGA_VS: outputs, 1 bit each; sync pulses, active low.
REQ-013 Port VGA_BLANK_N, VGA_SYNC_N: outputs, 1 bit each; VGA_BLANK_N is high in the active area; VGA_SYNC_N is held at 1.
REQ-014 Port frame_start: output, 1 bit; single-cycle pulse when h=0 and v=0.
REQ-015 Port spi_err: output, 1 bit; single-cycle pulse when a frame is discarded.

Function
REQ-016 The h counter SHALL count 0..H_TOTAL-1, then wrap to 0.
REQ-017 The v counter SHALL increment when h wraps and SHALL wrap to 0 after V_TOTAL-1.
REQ-018 hs_n SHALL be 0 for h < H_SYNC; vs_n SHALL be 0 for v < V_SYNC.
REQ-019 The active area SHALL be H_ACT_S <= h < H_ACT_E and V_ACT_S <= v < V_ACT_E.
REQ-020 All VGA outputs SHALL be registered, with a fixed 1-cycle latency from the counter values.
REQ-021 Outside the active area, RGB SHALL be 0 and VGA_BLANK_N SHALL be 0.
REQ-022 Geometry: x = h-H_ACT_S, bar index b = x / BAR_W, col = x % BAR_W, row = V_ACT_E-1-v (bottom row is 0).
REQ-023 Pixel priority SHALL be, highest first: separator, peak marker, bar body, background.
REQ-024 Separator: if col >= BAR_W-3 or b >= N_BARS, the pixel SHALL be RGB 0.
REQ-025 Peak marker: if row / V_SCALE == peak[b], the pixel SHALL be RGB 0xFF,0xFF,0xFF.
REQ-026 Bar body: if row < act[b]*V_SCALE, the pixel SHALL be R = row[8:1], G = 0xFF-row[8:1], B = 0.
REQ-027 Background SHALL be RGB 0x60,0x60,0x60.
REQ-028 The level-times-V_SCALE product SHALL be computed without truncation; row is compared at full width.
REQ-029 spi_clk, spi_csel and spi_mosi SHALL each pass through a 2-flop synchroniser before use; edges are detected on the synchronised signals.
REQ-030 On each synchronised spi_clk rising edge while csel=1, the receiver SHALL shift right: pkt = {mosi, pkt[15:1]}, and increment the bit count, saturating at 17.
REQ-031 A csel rising edge SHALL clear the bit count.
REQ-032 On a csel falling edge with bit count == 16 and pkt[7:0] < N_BARS, the receiver SHALL write shadow[pkt[7:0]] = pkt[15:8] (LVL_W bits).
REQ-033 On a csel falling edge with bit count != 16 or address >= N_BARS, no write SHALL occur and spi_err SHALL pulse 1 cycle.
REQ-034 Double buffer: act SHALL be loaded from shadow only on the frame_start cycle, giving tear-free display.
REQ-035 On a frame_start cycle, each peak[b] SHALL become max(shadow[b], sat0(peak[b]-DECAY)), evaluated from pre-update values.
REQ-036 An SPI write landing on the frame_start cycle SHALL take effect in shadow and SHALL be copied to act at the next frame_start.
REQ-037 Register widths: h is clog2(H_TOTAL) bits; v is clog2(V_TOTAL) bits; no wrap aliasing.

Reset
REQ-038 While KEY[0]=0 at a clock edge: h=v=0; all shadow, act and peak entries = 0; pkt=0; bit count=0; synchronisers=0.
REQ-039 While KEY[0]=0, the outputs SHALL be: RGB 0, VGA_HS=0, VGA_VS=0, VGA_BLANK_N=0, frame_start=0, spi_err=0.
REQ-040 A reset mid-SPI-frame SHALL discard the partial packet; the first post-reset write SHALL need a fresh csel rising edge.
REQ-041 The first frame_start SHALL occur on the first clock after reset is released.

Verification
REQ-042 Bench SHALL run reset then 2 frames and check HS low for 141 of 1050 clocks, VS low for 6 of 798 lines, and frame_start once per 837900 clocks.
REQ-043 Bench SHALL send SPI frame addr 3, data 100 mid-frame and check act[3] unchanged until the next frame_start; then rows 0..199 of bar 3 show the body and row 200 shows white.
REQ-044 Bench SHALL write bar 0 = 50 and then 0 and check the peak reads 50, 49, 48 on successive frames (DECAY=1), reaching 0 after 50 frames with no underflow.
REQ-045 Bench SHALL send a 15-bit frame and a frame with addr 20 (N_BARS=15) and check spi_err pulses once each and shadow is unchanged.
REQ-046 Bench SHALL check columns x=50..52 of every bar and x >= 795 are black, and pixels outside the active area are 0 with BLANK_N=0.
REQ-047 Bench SHALL assert KEY[0]=0 after 8 SPI bits, then release it and send a full frame to addr 1, data 7, and check that only addr 1 is written.
